mem_arbiter: RTL and testbench

- Shares one single-port data/instruction memory between the instruction fetcher (IF port) and the load/store datapath (D port). This supports the move from the single-cycle core to a multi-cycle core with a unified memory.
- Serialises accesses through a small FSM and returns read data with a fixed latency.
- Data has priority over fetch, with a starvation guard so fetch always makes progress.
- Sits between the CPU's Fetcher/load-store path and the Memory block.

---
 rtl/mem_arbiter_pkg.sv | 12 +
 rtl/mem_arb_starve.sv | 42 ++++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types for the unified-memory arbiter
package mem_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_arb_starve.sv
// rtl/mem_arb_starve.sv - data-first priority pick with a saturating fetch starvation guard
module mem_arb_starve
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic d_req,
  input  logic grant_enable,
  output logic if_win,
  output logic d_win
);

  localparam int SW = cnt_w(STARVE_MAX + 1);

  logic [SW-1:0] starve_q, starve_d;
  logic          if_forced;

  always_comb begin
    if_forced = (starve_q == SW'(STARVE_MAX));
    d_win     = grant_enable && d_req && !(if_req && if_forced);
    if_win    = grant_enable && if_req && !d_win;
    starve_d  = starve_q;
    // D can only beat a pending fetch below the limit, so this never overflows.
    if (d_win && if_req) begin
      starve_d = starve_q + SW'(1);
    end else if (if_win || !if_req) begin
      starve_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serialises fetch and load/store traffic onto one single-port memory
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1,
  parameter int STARVE_MAX  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int LW = cnt_w(MEM_LATENCY);

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] resp_q, resp_d;
  logic              grant_enable, if_win, d_win;

  // Grants are held off during reset so every output is quiet while rst is low.
  assign grant_enable = rst && (state_q != ACCESS);

  mem_arb_starve #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk          (clk),
    .rst          (rst),
    .if_req       (if_req),
    .d_req        (d_req),
    .grant_enable (grant_enable),
    .if_win       (if_win),
    .d_win        (d_win)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    lat_d     = lat_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    resp_d    = resp_q;
    if_gnt    = if_win;
    d_gnt     = d_win;
    busy      = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = '0;
    d_rdata   = '0;

    case (state_q)
      IDLE: begin
      end
      ACCESS: begin
        busy      = 1'b1;
        mem_addr  = addr_q;
        mem_we    = we_q && (lat_q == '0);
        mem_wdata = wdata_q;
        if (lat_q == LW'(MEM_LATENCY - 1)) begin
          resp_d  = we_q ? '0 : mem_rdata;
          lat_d   = '0;
          state_d = RESP;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      RESP: begin
        if (owner_q == OWN_IF) begin
          if_rvalid = 1'b1;
          if_rdata  = resp_q;
        end else begin
          d_rvalid = 1'b1;
          d_rdata  = resp_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A grant can only fire in IDLE or RESP, so it overrides the fall-back above.
    if (if_win || d_win) begin
      owner_d = d_win ? OWN_D : OWN_IF;
      addr_d  = d_win ? d_addr : if_addr;
      we_d    = d_win && d_we;
      wdata_d = d_win ? d_wdata : '0;
      lat_d   = '0;
      state_d = ACCESS;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      lat_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      lat_q   <= lat_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomised checks of mem_arbiter against a transaction model
module tb_mem_arbiter;

  localparam int LAT = 3;
  localparam int SM  = 4;
  localparam logic [31:0] AMASK = 32'hFFFF_FC3C;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_we, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  function automatic logic [31:0] mem_init(input int i);
    if (i == 16) return 32'h2002_0005;
    return (32'(i) * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  // Memory: data only valid once the address has been held LAT cycles.
  logic [31:0] mem [256];
  logic        mem_init_done = 1'b0;
  int          hold = 0;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= mem_init(i);
      mem_init_done <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
    hold <= busy ? hold + 1 : 0;
  end

  assign mem_rdata = (busy && hold >= LAT - 1) ? mem[mem_addr[9:2]] : 32'hBAD0_BAD0;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: one access at a time, identified by the cycle its ACCESS starts.
  logic [31:0] ref_mem [256];
  int          cyc = 0;
  bit          acc_valid = 0;
  int          acc_start = 0;
  bit          acc_is_d;
  bit          acc_we;
  logic [31:0] acc_addr, acc_wdata, acc_data;
  int          starve = 0;
  bit          e_if_gnt, e_d_gnt;
  logic        o_if_gnt, o_d_gnt, o_if_rvalid, o_d_rvalid, o_mem_we, o_busy;
  logic [31:0] o_if_rdata, o_d_rdata, o_mem_addr;

  task automatic step();
    bit in_acc, resp;
    @(negedge clk);
    in_acc   = acc_valid && cyc >= acc_start && cyc < acc_start + LAT;
    resp     = acc_valid && cyc == acc_start + LAT;
    e_d_gnt  = !in_acc && d_req && !(if_req && starve == SM);
    e_if_gnt = !in_acc && if_req && !e_d_gnt;
    check("if_gnt", if_gnt, e_if_gnt);
    check("d_gnt", d_gnt, e_d_gnt);
    check("busy", busy, in_acc);
    check("mem_addr", mem_addr, in_acc ? acc_addr : 32'h0);
    check("mem_we", mem_we, in_acc && acc_we && cyc == acc_start);
    check("mem_wdata", mem_wdata, in_acc ? acc_wdata : 32'h0);
    check("if_rvalid", if_rvalid, resp && !acc_is_d);
    check("d_rvalid", d_rvalid, resp && acc_is_d);
    check("if_rdata", if_rdata, (resp && !acc_is_d) ? acc_data : 32'h0);
    check("d_rdata", d_rdata, (resp && acc_is_d) ? acc_data : 32'h0);
    o_if_gnt = if_gnt;   o_d_gnt = d_gnt;     o_if_rvalid = if_rvalid; o_d_rvalid = d_rvalid;
    o_if_rdata = if_rdata; o_d_rdata = d_rdata; o_mem_we = mem_we; o_busy = busy; o_mem_addr = mem_addr;
    if (e_if_gnt || e_d_gnt) begin
      acc_valid = 1;
      acc_start = cyc + 1;
      acc_is_d  = e_d_gnt;
      acc_addr  = e_d_gnt ? d_addr : if_addr;
      acc_we    = e_d_gnt && d_we;
      acc_wdata = e_d_gnt ? d_wdata : 32'h0;
      if (acc_we) begin
        ref_mem[acc_addr[9:2]] = d_wdata;
        acc_data = 32'h0;
      end else begin
        acc_data = ref_mem[acc_addr[9:2]];
      end
    end
    if (e_if_gnt) starve = 0;
    else if (e_d_gnt && if_req) starve = (starve < SM) ? starve + 1 : SM;
    else if (!if_req) starve = 0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic req_if(input logic [31:0] a, output int gc);
    bit got = 0;
    if_req = 1'b1; if_addr = a; gc = -1;
    for (int k = 0; k < 50 && !got; k++) begin
      step();
      if (o_if_gnt) begin got = 1; gc = cyc - 1; end
    end
    if_req = 1'b0;
    check("if_gnt_seen", got, 1);
  endtask

  task automatic req_d(input logic we, input logic [31:0] a, input logic [31:0] wd, output int gc);
    bit got = 0;
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; gc = -1;
    for (int k = 0; k < 50 && !got; k++) begin
      step();
      if (o_d_gnt) begin got = 1; gc = cyc - 1; end
    end
    d_req = 1'b0;
    check("d_gnt_seen", got, 1);
  endtask

  task automatic drain(output int we_cnt, output int busy_cnt, output bit rv, output logic [31:0] rd);
    we_cnt = 0; busy_cnt = 0; rv = 0; rd = 32'h0;
    for (int k = 0; k < LAT + 1; k++) begin
      step();
      we_cnt   += int'(o_mem_we);
      busy_cnt += int'(o_busy);
      if (o_d_rvalid) begin rv = 1; rd = o_d_rdata; end
      if (o_if_rvalid) begin rv = 1; rd = o_if_rdata; end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, g2, prev, wc, bc, rvc;
    bit rv, got;
    logic [31:0] rd;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem_init(i);

    // Reset with both requesters active: nothing may be granted.
    rst = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    if_addr = 32'h40; d_addr = 32'h80; d_wdata = 32'h1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_if_gnt", if_gnt, 0);
    check("rst_d_gnt", d_gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_rvalid", {if_rvalid, d_rvalid}, 0);
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    step();

    // Single fetch.
    req_if(32'h40, g);
    step();
    check("fetch_mem_addr", o_mem_addr, 32'h40);
    repeat (LAT - 1) step();
    step();
    check("fetch_rvalid", o_if_rvalid, 1);
    check("fetch_rdata", o_if_rdata, 32'h2002_0005);

    // Store then load the same word.
    req_d(1'b1, 32'h100, 32'hDEAD_BEEF, g);
    drain(wc, bc, rv, rd);
    check("store_we_once", wc, 1);
    check("store_busy_cycles", bc, LAT);
    check("store_rvalid", rv, 1);
    check("store_rdata_zero", rd, 0);
    req_d(1'b0, 32'h100, 32'h0, g);
    drain(wc, bc, rv, rd);
    check("load_rvalid", rv, 1);
    check("load_rdata", rd, 32'hDEAD_BEEF);

    // Continuous contention: four D wins then one IF, at one grant per LAT+1 cycles.
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = $urandom & AMASK; d_addr = $urandom & AMASK;
    prev = -1;
    for (int n = 0; n < 10; n++) begin
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
        step();
        if (o_if_gnt || o_d_gnt) got = 1;
      end
      check("cont_gnt_seen", got, 1);
      check("cont_winner_if", o_if_gnt, (n % 5) == 4);
      if (prev >= 0) check("cont_spacing", cyc - 1 - prev, LAT + 1);
      prev = cyc - 1;
      if (o_d_gnt) d_addr = $urandom & AMASK;
      else if_addr = $urandom & AMASK;
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (LAT + 2) step();

    // Address change after grant must not reach the memory.
    req_d(1'b0, 32'h100, 32'h0, g);
    d_addr = 32'h200;
    step();
    check("addr_latched", o_mem_addr, 32'h100);
    repeat (LAT) step();

    // Reset in the second ACCESS cycle drops the access.
    req_d(1'b0, 32'h140, 32'h0, g);
    step();
    #2;
    rst = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_mem_addr", mem_addr, 0);
    check("midrst_rvalid", {if_rvalid, d_rvalid}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    acc_valid = 0; starve = 0; cyc++;
    rvc = 0;
    for (int k = 0; k < LAT + 2; k++) begin
      step();
      rvc += int'(o_if_rvalid) + int'(o_d_rvalid);
    end
    check("midrst_no_rvalid", rvc, 0);
    g2 = cyc;
    req_if(32'h40, g);
    check("midrst_idle_gnt", g - g2, 0);
    repeat (LAT + 1) step();

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      if (!if_req) begin
        if ($urandom_range(0, 3) == 0) begin if_req = 1'b1; if_addr = $urandom & AMASK; end
      end else if ($urandom_range(0, 31) == 0) begin
        if_req = 1'b0;
      end
      if (!d_req) begin
        if ($urandom_range(0, 2) == 0) begin
          d_req = 1'b1; d_we = 1'($urandom); d_addr = $urandom & AMASK; d_wdata = $urandom;
        end
      end else if ($urandom_range(0, 31) == 0) begin
        d_req = 1'b0;
      end
      step();
      if (e_if_gnt) begin if_req = 1'b0; if_addr = $urandom; end
      if (e_d_gnt) begin d_req = 1'b0; d_addr = $urandom; d_wdata = $urandom; end
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (LAT + 2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
